// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_types_pkg: shared word, RAM status and arbiter state types.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNOOP  = 3'd1,
    C2C    = 3'd2,
    DREAD  = 3'd3,
    DWRITE = 3'd4,
    IFETCH = 3'd5
  } arb_state_t;

  // Core rr keeps the grant if it asks; otherwise the other core gets it.
  function automatic logic rr_pick(input logic [1:0] req, input logic rr);
    return req[rr] ? rr : ~rr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coherence_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2: two-way round-robin grant over dcache and icache classes.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arbiter2
  import cpu_types_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] dreq,
  input  logic [1:0] ireq,
  input  logic       done,
  input  logic       done_core,
  output logic       gnt_valid,
  output logic       gnt_core,
  output logic       gnt_d
);

  logic rr_q;
  logic rr_d;

  // Only dcache completions advance the shared pointer.
  always_comb begin
    rr_d = rr_q;
    if (done) begin
      rr_d = ~done_core;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign gnt_d     = |dreq;
  assign gnt_valid = (|dreq) | (|ireq);
  assign gnt_core  = gnt_d ? rr_pick(dreq, rr_q) : rr_pick(ireq, rr_q);

endmodule
`default_nettype wire

// File: rtl/coherence_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coherence_arbiter: shares the RAM port between two cores and runs    |
// | snoop coherence between their dcaches. Revision: 1.0                  |
// +----------------------------------------------------------------------+
module coherence_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCPU         = 2,
  parameter int SNOOP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NCPU-1:0]      iREN,
  input  word_t [NCPU-1:0]     iaddr,
  output logic [NCPU-1:0]      iwait,
  output word_t [NCPU-1:0]     iload,
  input  logic [NCPU-1:0]      dREN,
  input  logic [NCPU-1:0]      dWEN,
  input  word_t [NCPU-1:0]     daddr,
  input  word_t [NCPU-1:0]     dstore,
  output logic [NCPU-1:0]      dwait,
  output word_t [NCPU-1:0]     dload,
  input  logic [NCPU-1:0]      ccwrite,
  input  logic [NCPU-1:0]      cctrans,
  input  logic [NCPU-1:0]      ccdirty,
  output logic [NCPU-1:0]      ccwait,
  output logic [NCPU-1:0]      ccinv,
  output word_t [NCPU-1:0]     ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  logic [1:0]           ramstate
);

  arb_state_t state_q, state_d;
  logic       c_q, c_d;
  logic [1:0] cnt_q, cnt_d;
  logic       o;
  logic       acc;
  logic       d_done;
  logic       gnt_valid, gnt_core, gnt_d;
  logic       unused;

  assign o      = ~c_q;
  assign acc    = (ramstate == ACCESS);
  assign unused = ^cctrans;

  rr_arbiter2 u_rr (
    .clk       (CLK),
    .rst_n     (nRST),
    .dreq      (dREN | dWEN),
    .ireq      (iREN),
    .done      (d_done),
    .done_core (c_q),
    .gnt_valid (gnt_valid),
    .gnt_core  (gnt_core),
    .gnt_d     (gnt_d)
  );

  // Outputs decode straight from state so completion tracks ACCESS in-cycle
  // and an asserted reset clears them without waiting for a clock.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    d_done      = 1'b0;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          c_d   = gnt_core;
          cnt_d = '0;
          if (!gnt_d)                state_d = IFETCH;
          else if (dREN[gnt_core])   state_d = SNOOP;
          else                       state_d = DWRITE;
        end
      end
      SNOOP: begin
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[c_q];
        ccinv[o]       = ccwrite[c_q];
        cnt_d          = cnt_q + 2'd1;
        if (cnt_q == 2'(SNOOP_CYCLES - 1)) begin
          state_d = ccdirty[o] ? C2C : DREAD;
        end
      end
      C2C: begin
        // The dirty peer writes back to RAM while forwarding the same word.
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[c_q];
        ramWEN         = 1'b1;
        ramaddr        = daddr[o];
        ramstore       = dstore[o];
        dload[c_q]     = dstore[o];
        if (acc) begin
          dwait[c_q] = 1'b0;
          dwait[o]   = 1'b0;
          d_done     = 1'b1;
          state_d    = IDLE;
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[c_q];
        if (acc) begin
          dwait[c_q] = 1'b0;
          dload[c_q] = ramload;
          d_done     = 1'b1;
          state_d    = IDLE;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[c_q];
        ramstore = dstore[c_q];
        if (acc) begin
          dwait[c_q] = 1'b0;
          d_done     = 1'b1;
          state_d    = IDLE;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[c_q];
        if (acc) begin
          iwait[c_q] = 1'b0;
          iload[c_q] = ramload;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coherence_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_coherence_arbiter: directed stimulus with a completion scoreboard. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_coherence_arbiter;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST = 1'b1;
  logic [1:0]       iREN = '0, dREN = '0, dWEN = '0;
  logic [1:0]       ccwrite = '0, cctrans = '0, ccdirty = '0;
  logic [1:0][31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int         errors = 0;
  int         checks = 0;
  int         stall_left = 0;
  logic [1:0] stall_kind = BUSY;
  logic [1:0] seen_iw = 2'b11, seen_dw = 2'b11;
  logic       seen_ram = 1'b0;

  typedef struct {
    string       nm;
    logic [1:0]  iw, dw, ilm, dlm;
    logic [31:0] ld;
    logic        ren, wen;
    logic [31:0] addr, store;
  } exp_t;
  exp_t q[$];
  exp_t cur;

  coherence_arbiter #(.NCPU(2), .SNOOP_CYCLES(1)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ccwrite(ccwrite), .cctrans(cctrans), .ccdirty(ccdirty),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: data is address XOR 0x5A5A0000; stalls reported before ACCESS.
  assign ramload  = ramaddr ^ 32'h5A5A_0000;
  assign ramstate = !(ramREN || ramWEN) ? 2'(FREE)
                  : (stall_left != 0 ? stall_kind : 2'(ACCESS));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void expect_tr(string nm, logic [1:0] iw, logic [1:0] dw,
                                    logic [1:0] ilm, logic [1:0] dlm, logic [31:0] ld,
                                    logic ren, logic wen, logic [31:0] addr,
                                    logic [31:0] st);
    exp_t e;
    e.nm = nm; e.iw = iw; e.dw = dw; e.ilm = ilm; e.dlm = dlm; e.ld = ld;
    e.ren = ren; e.wen = wen; e.addr = addr; e.store = st;
    q.push_back(e);
  endfunction

  // Monitor: every cycle with a wait bit low must match the next expected record.
  always @(negedge CLK) begin
    seen_iw  = iwait;
    seen_dw  = dwait;
    seen_ram = ramREN | ramWEN;
    if (nRST && (iwait != 2'b11 || dwait != 2'b11)) begin
      if (q.size() == 0) begin
        chk("unexpected_completion", {28'd0, iwait, dwait}, 32'hF);
      end else begin
        cur = q.pop_front();
        chk({cur.nm, ".iwait"}, iwait, cur.iw);
        chk({cur.nm, ".dwait"}, dwait, cur.dw);
        chk({cur.nm, ".ramREN"}, ramREN, cur.ren);
        chk({cur.nm, ".ramWEN"}, ramWEN, cur.wen);
        chk({cur.nm, ".ramaddr"}, ramaddr, cur.addr);
        chk({cur.nm, ".on_access"}, ramstate, 2'(ACCESS));
        if (cur.wen) chk({cur.nm, ".ramstore"}, ramstore, cur.store);
        for (int k = 0; k < 2; k++) begin
          if (cur.ilm[k]) chk($sformatf("%s.iload%0d", cur.nm, k), iload[k], cur.ld);
          if (cur.dlm[k]) chk($sformatf("%s.dload%0d", cur.nm, k), dload[k], cur.ld);
        end
      end
    end
  end

  // One clock; requesters drop their request after seeing their wait low.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (seen_ram && stall_left > 0) stall_left--;
    for (int k = 0; k < 2; k++) begin
      if (!seen_dw[k]) begin dREN[k] = 1'b0; dWEN[k] = 1'b0; end
      if (!seen_iw[k]) iREN[k] = 1'b0;
    end
  endtask

  task automatic drain(input string nm, input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk({nm, ".drained"}, q.size(), 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 nRST = 1'b0;
    #20;
    chk("rst.iwait", iwait, 2'b11);
    chk("rst.dwait", dwait, 2'b11);
    chk("rst.ramREN", ramREN, 1'b0);
    chk("rst.ramWEN", ramWEN, 1'b0);
    chk("rst.ramaddr", ramaddr, 32'h0);
    chk("rst.ccwait", {ccwait, ccinv}, 4'h0);
    chk("rst.loads", iload[0] | iload[1] | dload[0] | dload[1], 32'h0);
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle.no_ram", ramREN | ramWEN, 1'b0);
    end

    // Two simultaneous reads: core0 first, then core1.
    daddr[0] = 32'h100; daddr[1] = 32'h200;
    expect_tr("rd_c0", 2'b11, 2'b10, 2'b00, 2'b01, 32'h5A5A_0100, 1'b1, 1'b0, 32'h100, 32'h0);
    expect_tr("rd_c1", 2'b11, 2'b01, 2'b00, 2'b10, 32'h5A5A_0200, 1'b1, 1'b0, 32'h200, 32'h0);
    dREN = 2'b11;
    tick();
    chk("rd.snoop_ccwait", ccwait, 2'b10);
    chk("rd.snoop_addr1", ccsnoopaddr[1], 32'h100);
    chk("rd.snoop_ccinv", ccinv, 2'b00);
    drain("rd", 40);

    // Two simultaneous writebacks: rr is back at core0.
    daddr[0] = 32'h10; dstore[0] = 32'h11; daddr[1] = 32'h20; dstore[1] = 32'h22;
    expect_tr("wb_c0", 2'b11, 2'b10, 2'b00, 2'b00, 32'h0, 1'b0, 1'b1, 32'h10, 32'h11);
    expect_tr("wb_c1", 2'b11, 2'b01, 2'b00, 2'b00, 32'h0, 1'b0, 1'b1, 32'h20, 32'h22);
    dWEN = 2'b11;
    drain("wb", 40);

    // Read-for-ownership hitting a dirty line in core1.
    daddr[0] = 32'h80; daddr[1] = 32'h80; dstore[1] = 32'hDEAD_BEEF;
    ccwrite[0] = 1'b1; ccdirty[1] = 1'b1;
    expect_tr("c2c", 2'b11, 2'b00, 2'b00, 2'b01, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF);
    dREN[0] = 1'b1;
    tick();
    chk("c2c.snoop_ccinv", ccinv, 2'b10);
    chk("c2c.snoop_ccwait", ccwait, 2'b10);
    drain("c2c", 40);
    ccwrite = '0; ccdirty = '0;
    chk("c2c.after_ccwait", ccwait, 2'b00);

    // dcache write beats the icache fetch issued in the same cycle.
    iaddr[0] = 32'h44; daddr[1] = 32'h30; dstore[1] = 32'h1234;
    expect_tr("mix_dw1", 2'b11, 2'b01, 2'b00, 2'b00, 32'h0, 1'b0, 1'b1, 32'h30, 32'h1234);
    expect_tr("mix_if0", 2'b10, 2'b11, 2'b01, 2'b00, 32'h5A5A_0044, 1'b1, 1'b0, 32'h44, 32'h0);
    iREN[0] = 1'b1; dWEN[1] = 1'b1;
    drain("mix", 40);

    // Fetch with five BUSY cycles before ACCESS.
    iaddr[0] = 32'h40; stall_kind = BUSY; stall_left = 5;
    expect_tr("busy_if0", 2'b10, 2'b11, 2'b01, 2'b00, 32'h5A5A_0040, 1'b1, 1'b0, 32'h40, 32'h0);
    iREN[0] = 1'b1;
    drain("busy", 40);

    // Writeback held through three ERROR cycles.
    daddr[0] = 32'h60; dstore[0] = 32'hCAFE_F00D; stall_kind = ERROR; stall_left = 3;
    dWEN[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err.ramWEN_held", ramWEN, 1'b1);
      chk("err.dwait_high", dwait, 2'b11);
      chk("err.ramaddr", ramaddr, 32'h60);
    end
    expect_tr("err_wb0", 2'b11, 2'b10, 2'b00, 2'b00, 32'h0, 1'b0, 1'b1, 32'h60, 32'hCAFE_F00D);
    drain("err", 40);

    // Reset asserted in the middle of a stalled read.
    daddr[0] = 32'h300; stall_kind = BUSY; stall_left = 10;
    dREN[0] = 1'b1;
    tick();
    tick();
    chk("midrst.dread_active", ramREN, 1'b1);
    nRST = 1'b0;
    #1;
    chk("midrst.ramREN", ramREN, 1'b0);
    chk("midrst.dwait", dwait, 2'b11);
    chk("midrst.ccwait", ccwait, 2'b00);
    dREN = '0; stall_left = 0;
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst.no_ram", ramREN | ramWEN, 1'b0);
    end

    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
